// File: rtl/counter_pkg.sv
//------------------------------------------------------------------------------
// Module : counter_pkg
// Brief  : Shared constants for the ripple counter and its bench.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

package counter_pkg;

    localparam int COUNTER_WIDTH = 4;

endpackage : counter_pkg

`default_nettype wire

// File: rtl/t_ff.sv
//------------------------------------------------------------------------------
// Module : t_ff
// Brief  : Toggle flip-flop with asynchronous active-high clear.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module t_ff (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= 1'b0;
        end else if (t) begin
            q <= ~q;
        end
    end

endmodule : t_ff

`default_nettype wire

// File: rtl/counter.sv
//------------------------------------------------------------------------------
// Module : counter
// Brief  : Asynchronous ripple binary up counter built from a chain of t_ff.
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module counter
    import counter_pkg::*;
#(
    parameter int WIDTH = COUNTER_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] stage_clk;
    logic [WIDTH-1:0] stage_t;

    assign stage_clk[0] = clk;
    assign stage_t[0]   = en;

    // Each higher stage is clocked by the falling edge of the stage below it.
    for (genvar i = 1; i < WIDTH; i++) begin : g_ripple
        assign stage_clk[i] = ~count[i-1];
        assign stage_t[i]   = 1'b1;
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        t_ff u_t_ff (
            .clk (stage_clk[i]),
            .rst (rst),
            .t   (stage_t[i]),
            .q   (count[i])
        );
    end

endmodule : counter

`default_nettype wire

// File: tb/tb_counter.sv
//------------------------------------------------------------------------------
// Module : tb_counter
// Brief  : Self-checking bench for counter (default and 8-bit builds).
// Rev    : 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_counter;
    import counter_pkg::*;

    logic       clk;
    logic       rst;
    logic       en;
    logic [COUNTER_WIDTH-1:0] count4;
    logic [7:0] count8;

    int n_checks;
    int n_fail;
    int model;   // enabled edges since last reset

    counter #(.WIDTH(COUNTER_WIDTH)) dut4 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (count4)
    );

    counter #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst   (rst),
        .en    (en),
        .count (count8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive en, wait for one rising edge, update the model, settle 1 ns.
    task automatic tick(input logic e);
        en = e;
        @(posedge clk);
        if (e) model = model + 1;
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        model = 0;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            n_checks++;
            if (count4 !== 4'd0 || count8 !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_initial: count4=%0h count8=%0h expected 0", count4, count8);
            end
        end
    endtask

    task automatic test_first_run();
        // Now at 20 ns: release reset and count for 10 edges.
        rst = 1'b0;
        model = 0;
        for (int k = 1; k <= 10; k++) begin
            tick(1'b1);
            n_checks++;
            if (count4 !== 4'(k % 16) || count8 !== 8'(k)) begin
                n_fail++;
                $display("FAIL first_run edge %0d: count4=%0d count8=%0d expected %0d", k, count4, count8, k);
            end
        end
        @(negedge clk);
        n_checks++;
        if ($time != 120 || count8 !== 8'd10) begin
            n_fail++;
            $display("FAIL count_at_120ns: time=%0t count8=%0d expected 10", $time, count8);
        end
    endtask

    task automatic test_reset_hold();
        #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1'b1);
            n_checks++;
            if (count4 !== 4'd0 || count8 !== 8'd0) begin
                n_fail++;
                $display("FAIL reset_hold: count4=%0d count8=%0d expected 0", count4, count8);
            end
        end
        rst = 1'b0;
        model = 0;
        tick(1'b1);
        n_checks++;
        if (count4 !== 4'd1 || count8 !== 8'd1) begin
            n_fail++;
            $display("FAIL first_after_reset: count4=%0d count8=%0d expected 1", count4, count8);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] exp_seq [4] = '{4'd14, 4'd15, 4'd0, 4'd1};
        pulse_reset();
        for (int k = 0; k < 13; k++) tick(1'b1);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1);
            n_checks++;
            if (count4 !== exp_seq[k] || count8 !== 8'(model % 256)) begin
                n_fail++;
                $display("FAIL wrap step %0d: count4=%0d count8=%0d expected %0d/%0d",
                         k, count4, count8, exp_seq[k], model % 256);
            end
        end
    endtask

    task automatic test_hold();
        pulse_reset();
        for (int k = 0; k < 6; k++) tick(1'b1);
        for (int k = 0; k < 5; k++) begin
            tick(1'b0);
            n_checks++;
            if (count4 !== 4'd6 || count8 !== 8'd6) begin
                n_fail++;
                $display("FAIL hold: count4=%0d count8=%0d expected 6", count4, count8);
            end
        end
        for (int k = 7; k <= 8; k++) begin
            tick(1'b1);
            n_checks++;
            if (count4 !== 4'(k) || count8 !== 8'(k)) begin
                n_fail++;
                $display("FAIL resume: count4=%0d count8=%0d expected %0d", count4, count8, k);
            end
        end
    endtask

    task automatic test_async_reset();
        pulse_reset();
        for (int k = 0; k < 11; k++) tick(1'b1);
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (count4 !== 4'd0 || count8 !== 8'd0) begin
            n_fail++;
            $display("FAIL async_clear: count4=%0d count8=%0d expected 0", count4, count8);
        end
        #2;
        rst = 1'b0;
        model = 0;
        #1;
        n_checks++;
        if (count4 !== 4'd0 || count8 !== 8'd0) begin
            n_fail++;
            $display("FAIL after_pulse: count4=%0d count8=%0d expected 0", count4, count8);
        end
        tick(1'b1);
        n_checks++;
        if (count4 !== 4'd1 || count8 !== 8'd1) begin
            n_fail++;
            $display("FAIL post_reset_edge: count4=%0d count8=%0d expected 1", count4, count8);
        end
    endtask

    task automatic test_random();
        pulse_reset();
        for (int k = 0; k < 300; k++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset();
            tick(1'($urandom));
            n_checks++;
            if (count4 !== 4'(model % 16) || count8 !== 8'(model % 256)) begin
                n_fail++;
                $display("FAIL random step %0d: count4=%0d count8=%0d expected %0d/%0d",
                         k, count4, count8, model % 16, model % 256);
            end
        end
    endtask

    task automatic test_wide_300();
        int bad;
        bad = 0;
        pulse_reset();
        for (int k = 1; k <= 300; k++) begin
            tick(1'b1);
            if (count8 !== 8'(k % 256)) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL wide_sequence: %0d settled values differ from edges mod 256", bad);
        end
        n_checks++;
        if (count8 !== 8'd44 || count4 !== 4'(300 % 16)) begin
            n_fail++;
            $display("FAIL wide_300: count8=%0d count4=%0d expected 44/12", count8, count4);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        model    = 0;
        rst      = 1'b1;
        en       = 1'b0;
        test_reset();
        test_first_run();
        test_reset_hold();
        test_wrap();
        test_hold();
        test_async_reset();
        test_random();
        test_wide_300();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_counter

`default_nettype wire

// File: doc/counter.md
COUNTER -- requirements
Module: counter

Interface
REQ-001 Parameter WIDTH, default 4, number of count bits and ripple stages; legal range 1..32.
REQ-002 Port clk, input, 1, single clock; rising edge advances stage 0.
REQ-003 Port rst, input, 1, asynchronous active-high reset; clears all stages immediately, with no clock required.
REQ-004 Port en, input, 1, count enable; sampled on clk rising edge by stage 0 only.
REQ-005 Port count, output, WIDTH, current count; bit 0 is the LSB and is driven directly from the stage flip-flops.

Function
REQ-006 Counter SHALL be an asynchronous (ripple) binary up counter of WIDTH toggle stages; there is no other state.
REQ-007 Stage 0 SHALL toggle on each clk rising edge when en=1 and hold when en=0.
REQ-008 Stage i (i>=1) SHALL toggle when count[i-1] falls 1->0, i.e. clocked by the inverse of count[i-1], independent of clk and en.
REQ-009 After ripple settles, count SHALL equal previous count + 1 modulo 2^WIDTH per enabled clk edge; latency is one clk edge plus ripple delay (zero in RTL simulation).
REQ-010 Wrap-around: count = 2^WIDTH-1 plus an enabled edge SHALL yield 0 with no flag or saturation (WIDTH=4: 15 -> 0).
REQ-011 en deasserted SHALL freeze count at its present value indefinitely; reassertion resumes from that value.
REQ-012 Transient intermediate values during ripple are permitted; only settled values are specified.
REQ-013 Non-blocking assignment SHALL be used in every stage so that zero-delay simulation settles within the same timestep.

Reset
REQ-014 rst=1 SHALL force count to 0 asynchronously in every stage, overriding clk, en and ripple edges.
REQ-015 While rst=1, count SHALL stay 0 regardless of clk or en activity.
REQ-016 Reset asserted mid-count SHALL clear count at once; the 1->0 falls it produces SHALL NOT cause further toggles.
REQ-017 After rst deasserts, the first enabled clk rising edge SHALL produce count=1.
REQ-018 Reset value of every output: count = 0.

Structure
REQ-019 A shared package SHALL hold the default width constant (COUNTER_WIDTH = 4) used by the DUT, the interface and the bench.
REQ-020 One sub-module, t_ff, SHALL be used: a toggle flip-flop with inputs clk, rst (async, active-high) and t, and output q.
REQ-021 counter SHALL instantiate WIDTH t_ff stages in a generate loop. Stage 0 SHALL have clk=clk and t=en. Stage i SHALL have clk=~count[i-1] and t=1.
REQ-022 No combinational adder SHALL be used; the count SHALL arise only from the ripple chain.

Verification
REQ-023 clk period 10 ns, rst=1 for 0-20 ns, en=0 -> count=0 throughout; no X after time 0.
REQ-024 rst released at 20 ns, en=1, run to 120 ns -> 10 rising edges, count=10 at 120 ns, increasing by 1 per edge.
REQ-025 en=1 from count=13 for 4 edges -> 14, 15, 0, 1 (wrap-around).
REQ-026 count=6, en=0 for 5 edges, then en=1 for 2 edges -> holds 6, then 7, 8.
REQ-027 count=11, rst pulsed high for 3 ns between clk edges -> count=0 immediately, 1 after the next enabled edge.
REQ-028 WIDTH=8 build, en=1 for 300 edges after reset -> count=44 (300 mod 256), every settled value equal to edges mod 256.
